// File: rtl/uart_tx_mmio_if.sv
// Bus bundle between the address decoder / CPU side and the UART TX peripheral.
// we/wd carry the decoded store (we2 and write data); rd returns the status word.
interface uart_tx_mmio_if;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output we, output wd, input rd);
  modport slave  (input we, input wd, output rd);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: CPU stores are queued in a small FIFO and
// serialized as 8N1 frames on tx; a status word exposes busy/full/empty/
// overflow and the FIFO occupancy for polling.
module uart_tx_mmio #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_mmio_if.slave     bus,
  output logic              tx,
  output logic              tx_done
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE    = BAUD_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(FIFO_DEPTH);

  logic [1:0]        state;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  logic              full;
  logic              empty;
  logic              baud_zero;
  logic              wr_byte;
  logic              wr_clr;
  logic              pop;
  logic              push;
  logic [7:0]        head;

  // Only the low byte and the clear-overflow bit of a store carry meaning.
  logic              unused_wd;
  assign unused_wd = ^bus.wd[31:9];

  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);
  assign baud_zero = (baud == '0);
  assign head      = mem[rptr];
  assign wr_clr    = bus.we & bus.wd[8];
  assign wr_byte   = bus.we & ~bus.wd[8];

  // A byte leaves the FIFO when idle, or on the last stop-bit cycle so the
  // next frame starts without an idle gap.
  assign pop  = ~empty & ((state == S_IDLE) | ((state == S_STOP) & baud_zero));
  // A simultaneous pop frees a slot, so a store to a full FIFO still lands.
  assign push = wr_byte & (~full | pop);

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.wd[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (wr_clr)
        overflow <= 1'b0;
      else if (wr_byte & full & ~pop)
        overflow <= 1'b1;
    end
  end

  // Shift register: loaded on pop, shifted right at each data-bit boundary.
  always_ff @(posedge clk) begin
    if (pop)
      shift <= head;
    else if ((state == S_DATA) & baud_zero)
      shift <= {1'b0, shift[7:1]};
  end

  // Frame sequencer; tx is registered and set for the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      // tx_done covers exactly the final stop-bit cycle (baud counter at 0).
      tx_done <= (state == S_STOP) & (baud == BAUD_ONE);
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            state <= S_START;
            baud  <= BAUD_RELOAD;
            tx    <= 1'b0;
          end
        end
        S_START: begin
          if (baud_zero) begin
            state   <= S_DATA;
            baud    <= BAUD_RELOAD;
            bit_idx <= '0;
            tx      <= shift[0];
          end else begin
            baud <= baud - 1'b1;
          end
        end
        S_DATA: begin
          if (baud_zero) begin
            baud <= BAUD_RELOAD;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift[1];
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
        default: begin
          if (baud_zero) begin
            if (pop) begin
              state <= S_START;
              baud  <= BAUD_RELOAD;
              tx    <= 1'b0;
            end else begin
              state <= S_IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud <= baud - 1'b1;
          end
        end
      endcase
    end
  end

  // Status word, built purely from registered state.
  always_comb begin
    bus.rd              = '0;
    bus.rd[0]           = (state != S_IDLE) | ~empty;
    bus.rd[1]           = full;
    bus.rd[2]           = empty;
    bus.rd[3]           = overflow;
    bus.rd[3+CNT_W:4]   = count;
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: a serial monitor decodes frames from tx and compares
// each received byte against a queue of bytes the stimulus expects to be sent.
module tb_uart_tx_mmio;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic clk = 1'b0;
  logic rst;
  logic tx;
  logic tx_done;

  uart_tx_mmio_if bus ();

  uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .tx      (tx),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] sb[$];
  int exp_frames = 0;
  int done_cnt = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Serial monitor: mc counts cycles since the start bit began; sample mid-bit.
  int mc = -1;
  int mj;
  logic [7:0] mbyte;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      mc = -1;
    end else begin
      if (tx_done === 1'b1) done_cnt++;
      if (mc < 0 && tx === 1'b0) mc = 0;
      if (mc >= 0) begin
        if (mc % CPB == CPB / 2) begin
          mj = mc / CPB;
          if (mj == 0)
            check("start_bit", {31'b0, tx}, 32'h0);
          else if (mj <= 8)
            mbyte[mj-1] = tx;
          else begin
            check("stop_bit", {31'b0, tx}, 32'h1);
            if (sb.size() == 0)
              check("sb_nonempty", sb.size(), 32'd1);
            else
              check("rx_byte", {24'b0, mbyte}, {24'b0, sb.pop_front()});
          end
        end
        if (mc == 10 * CPB - 1) begin
          check("done_pulse", {31'b0, tx_done}, 32'h1);
          mc = -1;
        end else begin
          mc++;
        end
      end
    end
  end

  // One store on the next rising edge; call at a falling edge, returns at the next one.
  task automatic wr(input logic [31:0] v, input bit acc);
    bus.we = 1'b1;
    bus.wd = v;
    if (acc) begin
      sb.push_back(v[7:0]);
      exp_frames++;
    end
    @(negedge clk);
    bus.we = 1'b0;
    bus.wd = '0;
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    while (bus.rd !== 32'h4 && k < lim) begin
      @(negedge clk);
      k++;
    end
    check("idle_rd", bus.rd, 32'h4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int t[3];
  int nd;
  int k;

  initial begin
    rst = 1'b1;
    bus.we = 1'b0;
    bus.wd = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rd", bus.rd, 32'h4);
    check("rst_tx", {31'b0, tx}, 32'h1);
    check("rst_done", {31'b0, tx_done}, 32'h0);

    // Single frame and first-byte latency.
    wr(32'h0000_00A5, 1'b1);
    check("lat_rd_queued", bus.rd, 32'h11);
    check("lat_tx_high", {31'b0, tx}, 32'h1);
    @(negedge clk);
    check("tx_fall", {31'b0, tx}, 32'h0);
    check("lat_rd_popped", bus.rd, 32'h5);
    wait_idle(100);

    // Fill, overflow, clear overflow.
    wr(32'h11, 1'b1);
    wr(32'h22, 1'b1);
    wr(32'h33, 1'b1);
    wr(32'h44, 1'b1);
    wr(32'h55, 1'b1);
    check("full_no_ovf", bus.rd, 32'h43);
    wr(32'h66, 1'b0);
    check("ovf_set", bus.rd, 32'h4B);
    wr(32'h100, 1'b0);
    check("ovf_clr", bus.rd, 32'h43);
    wait_idle(400);

    // Back-to-back frames spaced by exactly one frame time.
    wr(32'hC3, 1'b1);
    wr(32'h5A, 1'b1);
    wr(32'h0F, 1'b1);
    nd = 0;
    t[0] = 0; t[1] = 0; t[2] = 0;
    k = 0;
    while (nd < 3 && k < 200) begin
      @(negedge clk);
      k++;
      if (tx_done === 1'b1) begin
        t[nd] = cyc;
        nd++;
      end
    end
    check("b2b_count", nd, 32'd3);
    check("b2b_gap1", t[1] - t[0], 10 * CPB);
    check("b2b_gap2", t[2] - t[1], 10 * CPB);
    wait_idle(200);

    // Store to a full FIFO on the STOP-to-START pop edge.
    wr(32'hD1, 1'b1);
    wr(32'hD2, 1'b1);
    wr(32'hD3, 1'b1);
    wr(32'hD4, 1'b1);
    wr(32'hD5, 1'b1);
    k = 0;
    while (tx_done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("full_before_pop", bus.rd, 32'h43);
    wr(32'hD6, 1'b1);
    check("full_pop_wr", bus.rd, 32'h43);
    wait_idle(600);

    // Async reset in the middle of data bit 3.
    wr(32'h3C, 1'b1);
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_tx", {31'b0, tx}, 32'h1);
    check("midrst_rd", bus.rd, 32'h4);
    check("midrst_done", {31'b0, tx_done}, 32'h0);
    sb.delete();
    exp_frames--;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    repeat (50) @(negedge clk);
    check("no_resume_tx", {31'b0, tx}, 32'h1);
    check("no_resume_rd", bus.rd, 32'h4);
    wr(32'h96, 1'b1);
    wait_idle(100);

    // Stream ten bytes through the FIFO across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      k = 0;
      while (bus.rd[6:4] >= 3'd4 && k < 200) begin
        @(negedge clk);
        k++;
      end
      wr(32'h70 + i * 32'h9, 1'b1);
    end
    wait_idle(800);

    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    check("done_total", done_cnt, exp_frames);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
